tlc_profile_loader: RTL and testbench

Configuration sequencer for the tlc traffic light controller. It holds a table of timing profiles (red/yellow/green delays in seconds). On request, or automatically after reset, it programs the selected profile into tlc's three delay registers over tlc's addr/data/valid/ready write port. It sits between the host/config logic and tlc, and provides day/night or other timing-plan switching without host-side sequencing.

---
 rtl/tlc_profile_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_tlc_profile_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_profile_loader.sv
// ---------------------------------------------------------------------------
// tlc_profile_loader
//
// Configuration sequencer for the tlc traffic light controller. Holds a table
// of red/yellow/green delay profiles and, on request or automatically after
// reset, programs the selected profile into tlc's three delay registers
// through tlc's addr/data/valid/ready write port.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   cfg_we    table write strobe
//   cfg_prof  profile index for a table write
//   cfg_sel   field for a table write (0 red, 1 yellow, 2 green, 3 ignored)
//   cfg_data  value for a table write
//   load_req  load request, level sampled every edge
//   prof_sel  profile to load, sampled with load_req
//   addr      tlc register address
//   data      tlc register data
//   valid     write valid to tlc
//   ready     tlc accepts the write
//   busy      high while the sequencer is not idle
//   done      one-cycle pulse after a complete 3-register load
//   err       one-cycle pulse on a rejected or aborted load
// ---------------------------------------------------------------------------
module tlc_profile_loader #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_RED     = 0,
    parameter int ADDR_YELLOW  = 1,
    parameter int ADDR_GREEN   = 2,
    parameter int NUM_PROFILES = 4,
    parameter int PROF_WIDTH   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [PROF_WIDTH-1:0] cfg_prof,
    input  logic [1:0]            cfg_sel,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  load_req,
    input  logic [PROF_WIDTH-1:0] prof_sel,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_W_RED,
        S_W_YELLOW,
        S_W_GREEN,
        S_DONE,
        S_FAIL
    } state_t;

    function automatic logic prof_in_range(input logic [PROF_WIDTH-1:0] p);
        return int'(p) < NUM_PROFILES;
    endfunction

    // A zero delay would stall tlc forever in that phase, so such a profile
    // is refused rather than programmed.
    function automatic logic entry_ok(input logic [DATA_WIDTH-1:0] r,
                                      input logic [DATA_WIDTH-1:0] y,
                                      input logic [DATA_WIDTH-1:0] g);
        return (r != '0) && (y != '0) && (g != '0);
    endfunction

    // Profile table
    logic [DATA_WIDTH-1:0] tbl_red [NUM_PROFILES];
    logic [DATA_WIDTH-1:0] tbl_yel [NUM_PROFILES];
    logic [DATA_WIDTH-1:0] tbl_grn [NUM_PROFILES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                tbl_red[i] <= DATA_WIDTH'(3);
                tbl_yel[i] <= DATA_WIDTH'(1);
                tbl_grn[i] <= DATA_WIDTH'(5);
            end
        end else if (cfg_we && prof_in_range(cfg_prof)) begin
            case (cfg_sel)
                2'd0:    tbl_red[cfg_prof] <= cfg_data;
                2'd1:    tbl_yel[cfg_prof] <= cfg_data;
                2'd2:    tbl_grn[cfg_prof] <= cfg_data;
                default: ;
            endcase
        end
    end

    // Sequencer state
    state_t                state, state_n;
    logic                  pending, pending_n;
    logic [PROF_WIDTH-1:0] pend_idx, pend_idx_n;
    logic [PROF_WIDTH-1:0] cur_idx, cur_idx_n;
    logic [TCNT_W-1:0]     tcnt, tcnt_n;
    logic [DATA_WIDTH-1:0] snap_yel, snap_yel_n;
    logic [DATA_WIDTH-1:0] snap_grn, snap_grn_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;

    logic                  idx_ok;
    logic [DATA_WIDTH-1:0] rd_red, rd_yel, rd_grn;

    assign idx_ok = prof_in_range(cur_idx);
    assign rd_red = idx_ok ? tbl_red[cur_idx] : '0;
    assign rd_yel = idx_ok ? tbl_yel[cur_idx] : '0;
    assign rd_grn = idx_ok ? tbl_grn[cur_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pending  <= 1'b1;            // auto-load profile 0 after reset
            pend_idx <= '0;
            cur_idx  <= '0;
            tcnt     <= '0;
            snap_yel <= '0;
            snap_grn <= '0;
            addr     <= '0;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            pend_idx <= pend_idx_n;
            cur_idx  <= cur_idx_n;
            tcnt     <= tcnt_n;
            snap_yel <= snap_yel_n;
            snap_grn <= snap_grn_n;
            addr     <= addr_n;
            data     <= data_n;
            valid    <= valid_n;
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
            err      <= (state_n == S_FAIL);
        end
    end

    always_comb begin
        state_n    = state;
        pending_n  = pending;
        pend_idx_n = pend_idx;
        cur_idx_n  = cur_idx;
        tcnt_n     = tcnt;
        snap_yel_n = snap_yel;
        snap_grn_n = snap_grn;
        addr_n     = addr;
        data_n     = data;
        valid_n    = valid;

        // One-deep request queue: the newest request always wins.
        if (load_req) begin
            pending_n  = 1'b1;
            pend_idx_n = prof_sel;
        end

        case (state)
            S_IDLE: begin
                if (pending) begin
                    // Consume the queued index; a request arriving on the
                    // same edge stays queued for the following load.
                    state_n   = S_CHECK;
                    cur_idx_n = pend_idx;
                    pending_n = load_req;
                end else if (load_req) begin
                    // Fresh request while idle goes straight to CHECK so
                    // valid rises one cycle after acceptance.
                    state_n   = S_CHECK;
                    cur_idx_n = prof_sel;
                    pending_n = 1'b0;
                end
            end

            S_CHECK: begin
                if (!idx_ok || !entry_ok(rd_red, rd_yel, rd_grn)) begin
                    state_n = S_FAIL;
                end else begin
                    // Yellow/green are snapshotted so table writes during
                    // the load cannot tear the programmed profile.
                    state_n    = S_W_RED;
                    valid_n    = 1'b1;
                    addr_n     = ADDR_WIDTH'(ADDR_RED);
                    data_n     = rd_red;
                    snap_yel_n = rd_yel;
                    snap_grn_n = rd_grn;
                    tcnt_n     = '0;
                end
            end

            S_W_RED, S_W_YELLOW, S_W_GREEN: begin
                if (ready) begin
                    tcnt_n = '0;
                    if (state == S_W_RED) begin
                        state_n = S_W_YELLOW;
                        addr_n  = ADDR_WIDTH'(ADDR_YELLOW);
                        data_n  = snap_yel;
                    end else if (state == S_W_YELLOW) begin
                        state_n = S_W_GREEN;
                        addr_n  = ADDR_WIDTH'(ADDR_GREEN);
                        data_n  = snap_grn;
                    end else begin
                        state_n = S_DONE;
                        valid_n = 1'b0;
                    end
                end else if (tcnt == TCNT_W'(TIMEOUT)) begin
                    // Abort; registers already written in tlc stay written.
                    state_n = S_FAIL;
                    valid_n = 1'b0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end

            S_DONE:  state_n = S_IDLE;
            S_FAIL:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlc_profile_loader.sv
// ---------------------------------------------------------------------------
// tb_tlc_profile_loader
//
// Directed bench for tlc_profile_loader. A transaction-level model keeps the
// profile table and a queue of expected tlc events (register writes, done,
// err); a negedge monitor matches every DUT event against that queue and
// checks that a stalled write holds steady. Directed sequences pin cycle
// timing with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_tlc_profile_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_prof;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic       load_req;
    logic [1:0] prof_sel;
    logic [2:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    tlc_profile_loader dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_prof (cfg_prof),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .load_req (load_req),
        .prof_sel (prof_sel),
        .addr     (addr),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] a;
        logic [7:0] d;
    } ev_t;

    localparam logic [1:0] EV_W = 2'd0;
    localparam logic [1:0] EV_D = 2'd1;
    localparam logic [1:0] EV_E = 2'd2;

    ev_t        exp_q[$];
    logic [7:0] m_red [4];
    logic [7:0] m_yel [4];
    logic [7:0] m_grn [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [2:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    task automatic model_defaults();
        for (int i = 0; i < 4; i++) begin
            m_red[i] = 8'd3;
            m_yel[i] = 8'd1;
            m_grn[i] = 8'd5;
        end
    endtask

    // Expected outcome of loading profile idx with tlc always ready.
    task automatic predict_load(input int idx);
        if (m_red[idx] == 0 || m_yel[idx] == 0 || m_grn[idx] == 0) begin
            exp_q.push_back(mk_ev(EV_E, 3'd0, 8'd0));
        end else begin
            exp_q.push_back(mk_ev(EV_W, 3'd0, m_red[idx]));
            exp_q.push_back(mk_ev(EV_W, 3'd1, m_yel[idx]));
            exp_q.push_back(mk_ev(EV_W, 3'd2, m_grn[idx]));
            exp_q.push_back(mk_ev(EV_D, 3'd0, 8'd0));
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [2:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0d, expected no event", k, a, d);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        if (e.kind == EV_W && k == EV_W) begin
            chk("write_addr", a, e.a);
            chk("write_data", d, e.d);
        end
    endtask

    // Monitor: at negedge, valid&&ready means a transfer on the next posedge.
    logic       stall_p = 1'b0;
    logic [2:0] hold_a  = '0;
    logic [7:0] hold_d  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p && !err) begin
                chk("hold_valid", valid, 1);
                chk("hold_addr", addr, hold_a);
                chk("hold_data", data, hold_d);
            end
            chk("done_err_exclusive", done & err, 0);
            if (valid && ready) expect_ev(EV_W, addr, data);
            if (done) expect_ev(EV_D, 3'd0, 8'd0);
            if (err)  expect_ev(EV_E, 3'd0, 8'd0);
            stall_p = valid && !ready;
            hold_a  = addr;
            hold_d  = data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int p, input int s, input int d);
        cfg_prof = 2'(p);
        cfg_sel  = 2'(s);
        cfg_data = 8'(d);
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        if (s == 0) m_red[p] = 8'(d);
        if (s == 1) m_yel[p] = 8'(d);
        if (s == 2) m_grn[p] = 8'(d);
    endtask

    task automatic do_load(input int idx);
        prof_sel = 2'(idx);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_quiet(input int maxc);
        int q = 0;
        int n = 0;
        while (q < 3 && n < maxc) begin
            tick();
            n++;
            if (busy) q = 0;
            else      q++;
        end
        chk("idle_within_bound", (q >= 3), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b0;
        cfg_we   = 1'b0;
        cfg_prof = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        load_req = 1'b0;
        prof_sel = '0;
        ready    = 1'b1;
        model_defaults();
        predict_load(0);

        // Reset state and automatic load of profile 0
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        tick();
        chk("auto_check_busy", busy, 1);
        chk("auto_check_valid", valid, 0);
        tick();
        chk("auto_red_valid", valid, 1);
        chk("auto_red_addr", addr, 0);
        chk("auto_red_data", data, 3);
        tick();
        chk("auto_yel_addr", addr, 1);
        chk("auto_yel_data", data, 1);
        tick();
        chk("auto_grn_addr", addr, 2);
        chk("auto_grn_data", data, 5);
        tick();
        chk("auto_done", done, 1);
        chk("auto_done_valid", valid, 0);
        chk("auto_err", err, 0);
        tick();
        chk("auto_done_pulse", done, 0);
        chk("auto_busy_fall", busy, 0);

        // Reprogram profile 2; field 3 writes are dropped
        cfg_write(0, 3, 0);
        cfg_write(2, 0, 4);
        cfg_write(2, 1, 2);
        cfg_write(2, 2, 7);
        predict_load(2);
        do_load(2);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("latency_ready_high", n, 4);
        wait_quiet(20);

        // ready withheld for 3 cycles in the yellow phase
        predict_load(2);
        do_load(2);
        tick();
        tick();
        chk("stall_setup_addr", addr, 1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", valid, 1);
            chk("stall_addr", addr, 1);
            chk("stall_data", data, 2);
        end
        ready = 1'b1;
        tick();
        chk("post_stall_addr", addr, 2);
        chk("post_stall_data", data, 7);
        tick();
        chk("stall_done_at_7", done, 1);
        wait_quiet(20);

        // Zero green delay: rejected in CHECK
        cfg_write(1, 2, 0);
        predict_load(1);
        do_load(1);
        chk("rej_busy", busy, 1);
        chk("rej_err_early", err, 0);
        tick();
        chk("rej_err", err, 1);
        chk("rej_valid", valid, 0);
        chk("rej_done", done, 0);
        tick();
        chk("rej_err_pulse", err, 0);
        chk("rej_idle", busy, 0);
        cfg_write(1, 0, 2);
        cfg_write(1, 1, 3);
        cfg_write(1, 2, 6);
        cfg_write(3, 0, 9);
        cfg_write(3, 1, 8);
        cfg_write(3, 2, 7);

        // tlc never ready: abort after the timeout
        ready = 1'b0;
        exp_q.push_back(mk_ev(EV_E, 3'd0, 8'd0));
        do_load(0);
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        chk("timeout_window", (n >= 256 && n <= 258), 1);
        chk("timeout_valid_drop", valid, 0);
        ready = 1'b1;
        tick();
        chk("timeout_idle", busy, 0);
        predict_load(0);
        do_load(0);
        wait_quiet(30);

        // Requests during busy: latest wins, exactly one follow-up load
        predict_load(1);
        predict_load(3);
        do_load(1);
        tick();
        tick();
        prof_sel = 2'd2;
        load_req = 1'b1;
        tick();
        prof_sel = 2'd3;
        tick();
        load_req = 1'b0;
        wait_quiet(60);

        // Reset mid-load: valid drops at once, table returns to defaults
        predict_load(2);
        do_load(2);
        tick();
        chk("pre_reset_valid", valid, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_valid_async", valid, 0);
        chk("reset_busy_async", busy, 0);
        exp_q.delete();
        model_defaults();
        predict_load(0);
        tick();
        tick();
        rst = 1'b1;
        wait_quiet(30);
        predict_load(2);
        do_load(2);
        wait_quiet(30);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
